// File: rtl/req_issue_pkg.sv
// Shared types and defaults for the 4-channel request issuer.
// Imported by req_chan and req_issue4.
package req_issue_pkg;

    localparam int N_CH             = 4;
    localparam int CNT_W_DEF        = 3;
    localparam int WAIT_W_DEF       = 4;
    localparam int STARVE_LIMIT_DEF = 8;

    typedef enum logic {
        IDLE,
        WAIT
    } chan_state_t;

    function automatic logic is_onehot0(input logic [N_CH-1:0] v);
        return $countones(v) <= 1;
    endfunction

endpackage

// File: rtl/req_chan.sv
// One issue channel: token counter, wait/starve tracking, done pulse.
// Grants reach this block already qualified by the global one-hot check.
module req_chan
    import req_issue_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int WAIT_W       = WAIT_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             post,
    input  logic             gnt,
    input  logic             gnt_ok,
    output logic             req,
    output logic [CNT_W-1:0] pending,
    output logic             done,
    output logic             overflow,
    output logic             starve
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
    localparam logic [WAIT_W-1:0] LIMIT    = WAIT_W'(STARVE_LIMIT);

    chan_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  pend_d;
    logic              accept;
    logic              ovf_d;
    logic              hit_limit;

    assign req    = enable && (pending != '0);
    assign accept = gnt && req && gnt_ok;

    always_comb begin
        pend_d = pending;
        ovf_d  = 1'b0;
        if (post && !accept) begin
            if (pending == CNT_MAX) ovf_d = 1'b1;
            else pend_d = pending + 1'b1;
        end else if (accept && !post) begin
            pend_d = pending - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        if (!enable) begin
            state_d = IDLE;
            wait_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    wait_d = '0;
                    if (req) state_d = WAIT;
                end
                WAIT: begin
                    if (!req) begin
                        state_d = IDLE;
                        wait_d  = '0;
                    end else if (accept) begin
                        wait_d = '0;
                    end else if (wait_q != WAIT_MAX) begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    wait_d  = '0;
                end
            endcase
        end
        // Counter only rises by single steps, so this fires once per run.
        hit_limit = (wait_d == LIMIT) && (wait_q != LIMIT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            pending  <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            starve   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            pending  <= pend_d;
            done     <= accept;
            overflow <= overflow | ovf_d;
            starve   <= starve | hit_limit;
        end
    end

endmodule

// File: rtl/req_issue4.sv
// Requester front-end for the 4-way rotating-priority arbiter.
// Four token channels plus a global grant-protocol checker.
module req_issue4
    import req_issue_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int WAIT_W       = WAIT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       post,
    output logic [3:0]       req,
    output logic             en,
    input  logic [3:0]       gnt,
    output logic [3:0]       done,
    output logic [CNT_W-1:0] pending0,
    output logic [CNT_W-1:0] pending1,
    output logic [CNT_W-1:0] pending2,
    output logic [CNT_W-1:0] pending3,
    output logic [3:0]       overflow,
    output logic [3:0]       starve,
    output logic             proto_err
);

    logic             gnt_ok;
    logic [CNT_W-1:0] pending [N_CH];

    assign gnt_ok = is_onehot0(gnt);
    assign en     = enable && (|req);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        req_chan #(
            .CNT_W        (CNT_W),
            .WAIT_W       (WAIT_W),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .enable   (enable),
            .post     (post[i]),
            .gnt      (gnt[i]),
            .gnt_ok   (gnt_ok),
            .req      (req[i]),
            .pending  (pending[i]),
            .done     (done[i]),
            .overflow (overflow[i]),
            .starve   (starve[i])
        );
    end

    assign pending0 = pending[0];
    assign pending1 = pending[1];
    assign pending2 = pending[2];
    assign pending3 = pending[3];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            proto_err <= 1'b0;
        end else if (!gnt_ok || (|(gnt & ~req))) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_req_issue4.sv
// Directed testbench for req_issue4.
// Inputs change 1ns after posedge; outputs checked at that point.
module tb_req_issue4;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] post;
    logic [3:0] req;
    logic       en;
    logic [3:0] gnt;
    logic [3:0] done;
    logic [2:0] pending0, pending1, pending2, pending3;
    logic [3:0] overflow;
    logic [3:0] starve;
    logic       proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    req_issue4 dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .post      (post),
        .req       (req),
        .en        (en),
        .gnt       (gnt),
        .done      (done),
        .pending0  (pending0),
        .pending1  (pending1),
        .pending2  (pending2),
        .pending3  (pending3),
        .overflow  (overflow),
        .starve    (starve),
        .proto_err (proto_err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; post = '0; gnt = '0;
        tick(); tick();
        n_checks++;
        if ({req, en, pending0, pending1, pending2, pending3} !== '0) begin
            n_fail++;
            $display("FAIL reset_out: req=%b en=%b p=%0d%0d%0d%0d want all 0",
                     req, en, pending0, pending1, pending2, pending3);
        end
        reset = 1'b1; enable = 1'b1;
        tick();
        n_checks++;
        if (req !== 4'b0000 || en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_req: req=%b en=%b want 0000 0", req, en);
        end
        n_checks++;
        if ({done, overflow, starve, proto_err} !== '0) begin
            n_fail++;
            $display("FAIL idle_flags: done=%b ovf=%b stv=%b perr=%b want 0",
                     done, overflow, starve, proto_err);
        end
    endtask

    task automatic test_single();
        post = 4'b0001;
        tick();
        post = '0;
        n_checks++;
        if (req !== 4'b0001 || en !== 1'b1 || pending0 !== 3'd1) begin
            n_fail++;
            $display("FAIL single_post: req=%b en=%b p0=%0d want 0001 1 1",
                     req, en, pending0);
        end
        gnt = 4'b0001;
        tick();
        gnt = '0;
        n_checks++;
        if (done !== 4'b0001 || pending0 !== 3'd0 || req !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_gnt: done=%b p0=%0d req=%b want 0001 0 0000",
                     done, pending0, req);
        end
        tick();
        n_checks++;
        if (done !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_done_pulse: done=%b want 0000", done);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] g;
        logic [2:0] p [4];
        post = 4'b1111;
        tick(); tick();
        post = '0;
        n_checks++;
        if (req !== 4'b1111 || {pending0, pending1, pending2, pending3} !== 12'o2222) begin
            n_fail++;
            $display("FAIL b2b_fill: req=%b p=%0d%0d%0d%0d want 1111 2222",
                     req, pending0, pending1, pending2, pending3);
        end
        for (int k = 0; k < 8; k++) begin
            g = 4'b0001 << (k % 4);
            gnt = g;
            tick();
            p[0] = pending0; p[1] = pending1; p[2] = pending2; p[3] = pending3;
            n_checks++;
            if (done !== g || p[k % 4] !== ((k < 4) ? 3'd1 : 3'd0)) begin
                n_fail++;
                $display("FAIL b2b_step%0d: done=%b p=%0d want %b %0d",
                         k, done, p[k % 4], g, (k < 4) ? 1 : 0);
            end
        end
        gnt = '0;
        n_checks++;
        if (req !== 4'b0000 || proto_err !== 1'b0 || starve !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_end: req=%b perr=%b stv=%b want 0000 0 0000",
                     req, proto_err, starve);
        end
    endtask

    task automatic test_overflow();
        post = 4'b0100;
        for (int k = 0; k < 7; k++) tick();
        n_checks++;
        if (pending2 !== 3'd7 || overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL ovf_fill: p2=%0d ovf=%b want 7 0000", pending2, overflow);
        end
        tick();
        n_checks++;
        if (pending2 !== 3'd7 || overflow !== 4'b0100) begin
            n_fail++;
            $display("FAIL ovf_set: p2=%0d ovf=%b want 7 0100", pending2, overflow);
        end
        gnt = 4'b0100;
        tick();
        post = '0;
        n_checks++;
        if (pending2 !== 3'd7 || done !== 4'b0100 || overflow !== 4'b0100) begin
            n_fail++;
            $display("FAIL ovf_post_gnt: p2=%0d done=%b ovf=%b want 7 0100 0100",
                     pending2, done, overflow);
        end
        for (int k = 0; k < 7; k++) tick();
        gnt = '0;
        tick();
        n_checks++;
        if (pending2 !== 3'd0 || req !== 4'b0000 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drain: p2=%0d req=%b perr=%b want 0 0000 0",
                     pending2, req, proto_err);
        end
    endtask

    task automatic test_proto_multi();
        post = 4'b0011;
        tick();
        post = '0;
        gnt = 4'b0011;
        tick();
        gnt = '0;
        n_checks++;
        if (proto_err !== 1'b1 || pending0 !== 3'd1 || pending1 !== 3'd1 || done !== 4'b0000) begin
            n_fail++;
            $display("FAIL proto_multi: perr=%b p0=%0d p1=%0d done=%b want 1 1 1 0000",
                     proto_err, pending0, pending1, done);
        end
    endtask

    task automatic test_reset_mid();
        post = 4'b0001;
        tick(); tick();
        post = '0;
        n_checks++;
        if (pending0 !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_setup: p0=%0d want 3", pending0);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (pending0 !== 3'd0 || pending1 !== 3'd0 || req !== 4'b0000 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: p0=%0d p1=%0d req=%b perr=%b want 0 0 0000 0",
                     pending0, pending1, req, proto_err);
        end
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (done !== 4'b0000 || pending0 !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_nodone: done=%b p0=%0d want 0000 0", done, pending0);
        end
    endtask

    task automatic test_proto_idle();
        post = 4'b0001;
        tick();
        post = '0;
        gnt = 4'b1000;
        tick();
        gnt = '0;
        n_checks++;
        if (proto_err !== 1'b1 || pending3 !== 3'd0 || pending0 !== 3'd1 || done !== 4'b0000) begin
            n_fail++;
            $display("FAIL proto_idle: perr=%b p3=%0d p0=%0d done=%b want 1 0 1 0000",
                     proto_err, pending3, pending0, done);
        end
        gnt = 4'b0001;
        tick();
        gnt = '0;
        tick();
        n_checks++;
        if (pending0 !== 3'd0 || req !== 4'b0000) begin
            n_fail++;
            $display("FAIL proto_drain: p0=%0d req=%b want 0 0000", pending0, req);
        end
    endtask

    task automatic test_starve();
        post = 4'b0001;
        tick();
        post = '0;
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if (starve !== 4'b0000) begin
            n_fail++;
            $display("FAIL starve_early: starve=%b want 0000", starve);
        end
        tick();
        n_checks++;
        if (starve !== 4'b0001) begin
            n_fail++;
            $display("FAIL starve_set: starve=%b want 0001", starve);
        end
        enable = 1'b0;
        #1;
        n_checks++;
        if (req !== 4'b0000 || en !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_req: req=%b en=%b want 0000 0", req, en);
        end
        tick();
        n_checks++;
        if (pending0 !== 3'd1 || starve !== 4'b0001 || req !== 4'b0000) begin
            n_fail++;
            $display("FAIL disable_hold: p0=%0d stv=%b req=%b want 1 0001 0000",
                     pending0, starve, req);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_proto_multi();
        test_reset_mid();
        test_proto_idle();
        test_starve();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
